// File: rtl/fa_seq_chunk_pkg.sv
// Shared types for the chunked sequential adder/subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fa_seq_chunk_pkg;

  // Operation FSM encodings; 2'd3 is unused and recovers to idle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  // Chunk index counter width: clog2 of the chunk count, never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fa_seq_chunk_if.sv
// Start/busy/done request bus of the chunked adder/subtractor.
// Latency: n/a (wires only).
// Backpressure: start is ignored while busy; nothing is queued.
interface fa_seq_chunk_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic             sub;
  logic             ci;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ov;

  modport master (
    output start, sub, ci, a, b,
    input  busy, done, s, co, ov
  );

  modport slave (
    input  start, sub, ci, a, b,
    output busy, done, s, co, ov
  );
endinterface

// File: rtl/fa_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice.
// Latency: zero cycles (pure combinational).
// Backpressure: none.
module fa_chunk #(
  parameter int CHUNK = 4
) (
  output logic [CHUNK-1:0] s,
  output logic             co,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci
);

  // Ripple the carry from bit 0 upwards, one full adder per bit.
  always_comb begin
    logic c;
    c  = ci;
    s  = '0;
    for (int i = 0; i < CHUNK; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/fa_seq_chunk.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock through one fa_chunk slice.
// Latency: start cycle + NCH run cycles, done pulses in the following cycle (NCH+1).
// Backpressure: start accepted only in IDLE or DONE; start while busy is dropped.
module fa_seq_chunk
  import fa_seq_chunk_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic         clk,
  input  logic         rst,
  fa_seq_chunk_if.slave bus
);

  localparam int NCH  = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int IDXW = idx_width(NCH);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("fa_seq_chunk: WIDTH must be a positive multiple of CHUNK");
  end

  state_t            state;
  state_t            state_nxt;
  logic [IDXW-1:0]   idx;
  logic              carry;
  logic [WIDTH-1:0]  a_sh;
  logic [WIDTH-1:0]  b_sh;
  logic [WIDTH-1:0]  sum_sh;
  logic [WIDTH-1:0]  sum_nxt;
  logic [WIDTH-1:0]  s_r;
  logic              co_r;
  logic              ov_r;
  logic [CHUNK-1:0]  ch_s;
  logic              ch_co;
  logic              last;
  logic              accept;
  logic              busy;
  logic              done;

  // The single adder slice always works on the low chunk of the shift registers.
  fa_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .s  (ch_s),
    .co (ch_co),
    .a  (a_sh[CHUNK-1:0]),
    .b  (b_sh[CHUNK-1:0]),
    .ci (carry)
  );

  assign last    = (idx == IDXW'(NCH - 1));
  assign accept  = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
  // New sum chunk enters at the top; after NCH shifts chunk 0 sits at the LSBs.
  assign sum_nxt = WIDTH'({ch_s, sum_sh} >> CHUNK);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; the spare encoding falls back to idle.
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE: state_nxt = bus.start ? ST_RUN : ST_IDLE;
      ST_RUN:  state_nxt = last ? ST_DONE : ST_RUN;
      ST_DONE: state_nxt = bus.start ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, per-chunk accumulate, and result load on the last chunk.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      carry  <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      s_r    <= '0;
      co_r   <= 1'b0;
      ov_r   <= 1'b0;
    end else if (accept) begin
      // Subtract is a + ~b + ~borrow, so one adder covers both operations.
      idx    <= '0;
      a_sh   <= bus.a;
      b_sh   <= bus.sub ? ~bus.b : bus.b;
      carry  <= bus.sub ? ~bus.ci : bus.ci;
      sum_sh <= '0;
    end else if (state == ST_RUN) begin
      idx    <= idx + 1'b1;
      carry  <= ch_co;
      a_sh   <= a_sh >> CHUNK;
      b_sh   <= b_sh >> CHUNK;
      sum_sh <= sum_nxt;
      if (last) begin
        // Low chunk now holds the MSB chunk, so its top bits give the signs.
        s_r  <= sum_nxt;
        co_r <= ch_co;
        ov_r <= (a_sh[CHUNK-1] == b_sh[CHUNK-1]) && (ch_s[CHUNK-1] != a_sh[CHUNK-1]);
      end
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.s    = s_r;
  assign bus.co   = co_r;
  assign bus.ov   = ov_r;

endmodule

// File: tb/tb_fa_seq_chunk.sv
// Directed and randomised checks of fa_seq_chunk at CHUNK = 1, 4 and 16.
// Latency: expects done exactly NCH+1 cycles after the start cycle.
// Backpressure: exercises start while busy and start in the done cycle.
module tb_fa_seq_chunk;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  fa_seq_chunk_if #(.WIDTH(16)) if1  ();
  fa_seq_chunk_if #(.WIDTH(16)) if4  ();
  fa_seq_chunk_if #(.WIDTH(16)) if16 ();

  fa_seq_chunk #(.WIDTH(16), .CHUNK(1))  u_dut1  (.clk(clk), .rst(rst), .bus(if1));
  fa_seq_chunk #(.WIDTH(16), .CHUNK(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if4));
  fa_seq_chunk #(.WIDTH(16), .CHUNK(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_in(input int w, input logic st, input logic sb, input logic c,
                        input logic [15:0] aa, input logic [15:0] bb);
    case (w)
      1: begin if1.start = st; if1.sub = sb; if1.ci = c; if1.a = aa; if1.b = bb; end
      4: begin if4.start = st; if4.sub = sb; if4.ci = c; if4.a = aa; if4.b = bb; end
      default: begin if16.start = st; if16.sub = sb; if16.ci = c; if16.a = aa; if16.b = bb; end
    endcase
  endtask

  // Returns {busy, done, s, co, ov}.
  function automatic logic [19:0] get_out(input int w);
    case (w)
      1:       return {if1.busy, if1.done, if1.s, if1.co, if1.ov};
      4:       return {if4.busy, if4.done, if4.s, if4.co, if4.ov};
      default: return {if16.busy, if16.done, if16.s, if16.co, if16.ov};
    endcase
  endfunction

  // Reference: full-width arithmetic; returns {s, co, ov}.
  function automatic logic [17:0] model(input logic [15:0] aa, input logic [15:0] bb,
                                        input logic sb, input logic c);
    logic [16:0] r;
    logic        co;
    int          sr;
    if (!sb) r = {1'b0, aa} + {1'b0, bb} + {16'h0, c};
    else     r = {1'b0, aa} - {1'b0, bb} - {16'h0, c};
    co = sb ? ~r[16] : r[16];
    if (!sb) sr = int'($signed(aa)) + int'($signed(bb)) + int'(c);
    else     sr = int'($signed(aa)) - int'($signed(bb)) - int'(c);
    return {r[15:0], co, (sr > 32767) || (sr < -32768)};
  endfunction

  // One operation: start for one cycle, scramble inputs while busy, wait for done.
  task automatic run_op(input int w, input logic [15:0] aa, input logic [15:0] bb,
                        input logic sb, input logic c,
                        output logic [17:0] res, output int lat, output int bcnt,
                        output logic dn_after);
    logic [19:0] o;
    @(negedge clk);
    set_in(w, 1'b1, sb, c, aa, bb);
    @(negedge clk);
    set_in(w, 1'b0, ~sb, ~c, ~aa, ~bb);
    lat  = 1;
    bcnt = 0;
    o    = get_out(w);
    while (!o[18] && lat < 40) begin
      if (o[19]) bcnt++;
      @(negedge clk);
      lat++;
      o = get_out(w);
    end
    if (!o[18]) lat = -1;
    res = o[17:0];
    @(negedge clk);
    o = get_out(w);
    dn_after = o[18];
  endtask

  task automatic test_reset();
    logic [19:0] o;
    rst = 1'b1;
    set_in(1, 1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0001);
    set_in(4, 1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0001);
    set_in(16, 1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0001);
    repeat (2) @(negedge clk);
    o = get_out(4);
    n_tests++;
    if (o !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 00000", o);
    end
    set_in(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_in(4, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_in(16, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    rst = 1'b0;
    @(negedge clk);
    o = get_out(4);
    n_tests++;
    if (o !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_idle_after: got %h required 00000", o);
    end
  endtask

  task automatic test_add_basic();
    logic [17:0] res;
    int          lat, bc;
    logic        dn;
    run_op(4, 16'h00FF, 16'h0001, 1'b0, 1'b0, res, lat, bc, dn);
    n_tests++;
    if (res !== {16'h0100, 2'b00}) begin
      n_fail++;
      $display("FAIL add_basic_result: got %h required %h", res, {16'h0100, 2'b00});
    end
    n_tests++;
    if (lat !== 5) begin n_fail++; $display("FAIL add_basic_latency: got %0d required 5", lat); end
    n_tests++;
    if (bc !== 4) begin n_fail++; $display("FAIL add_basic_busy_cycles: got %0d required 4", bc); end
    n_tests++;
    if (dn !== 1'b0) begin n_fail++; $display("FAIL add_basic_done_width: got %b required 0", dn); end
  endtask

  task automatic test_add_edges();
    logic [17:0] res;
    int          lat, bc;
    logic        dn;
    run_op(4, 16'hFFFF, 16'h0000, 1'b0, 1'b1, res, lat, bc, dn);
    n_tests++;
    if (res !== {16'h0000, 2'b10}) begin
      n_fail++;
      $display("FAIL add_wrap: got %h required %h", res, {16'h0000, 2'b10});
    end
    run_op(4, 16'h7FFF, 16'h0001, 1'b0, 1'b0, res, lat, bc, dn);
    n_tests++;
    if (res !== {16'h8000, 2'b01}) begin
      n_fail++;
      $display("FAIL add_overflow: got %h required %h", res, {16'h8000, 2'b01});
    end
  endtask

  task automatic test_sub();
    logic [17:0] res;
    int          lat, bc;
    logic        dn;
    run_op(4, 16'h0005, 16'h0007, 1'b1, 1'b0, res, lat, bc, dn);
    n_tests++;
    if (res !== {16'hFFFE, 2'b00}) begin
      n_fail++;
      $display("FAIL sub_borrow: got %h required %h", res, {16'hFFFE, 2'b00});
    end
    run_op(4, 16'h8000, 16'h0001, 1'b1, 1'b0, res, lat, bc, dn);
    n_tests++;
    if (res !== {16'h7FFF, 2'b11}) begin
      n_fail++;
      $display("FAIL sub_overflow: got %h required %h", res, {16'h7FFF, 2'b11});
    end
    run_op(4, 16'h0009, 16'h0003, 1'b1, 1'b1, res, lat, bc, dn);
    n_tests++;
    if (res !== {16'h0005, 2'b10}) begin
      n_fail++;
      $display("FAIL sub_borrow_in: got %h required %h", res, {16'h0005, 2'b10});
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] o;
    int          cyc;
    @(negedge clk); cyc = 0; set_in(4, 1'b1, 1'b0, 1'b0, 16'h0003, 16'h0004);
    @(negedge clk); cyc = 1; set_in(4, 1'b0, 1'b0, 1'b0, 16'h0003, 16'h0004);
    @(negedge clk); cyc = 2; set_in(4, 1'b1, 1'b0, 1'b0, 16'h1111, 16'h1111);
    @(negedge clk); cyc = 3; set_in(4, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h1111);
    o = get_out(4);
    while (!o[18] && cyc < 40) begin @(negedge clk); cyc++; o = get_out(4); end
    n_tests++;
    if (cyc !== 5) begin n_fail++; $display("FAIL ignore_start_done_cycle: got %0d required 5", cyc); end
    n_tests++;
    if (o[17:2] !== 16'h0007) begin
      n_fail++;
      $display("FAIL ignore_start_result: got %h required 0007", o[17:2]);
    end
    set_in(4, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h1111);
    @(negedge clk); cyc++; set_in(4, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    o = get_out(4);
    n_tests++;
    if (o[19] !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b required 1", o[19]); end
    while (!o[18] && cyc < 40) begin @(negedge clk); cyc++; o = get_out(4); end
    n_tests++;
    if (cyc !== 10) begin n_fail++; $display("FAIL b2b_done_cycle: got %0d required 10", cyc); end
    n_tests++;
    if (o[17:2] !== 16'h2345) begin
      n_fail++;
      $display("FAIL b2b_result: got %h required 2345", o[17:2]);
    end
  endtask

  task automatic test_reset_abort();
    logic [19:0] o;
    logic [17:0] res;
    int          lat, bc, ndone;
    logic        dn;
    @(negedge clk); set_in(4, 1'b1, 1'b0, 1'b0, 16'h00FF, 16'h0001);
    @(negedge clk); set_in(4, 1'b0, 1'b0, 1'b0, 16'h00FF, 16'h0001);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    o = get_out(4);
    n_tests++;
    if (o !== 20'h0) begin n_fail++; $display("FAIL abort_outputs: got %h required 00000", o); end
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      o = get_out(4);
      if (o[18]) ndone++;
    end
    n_tests++;
    if (ndone !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d required 0", ndone); end
    run_op(4, 16'h1234, 16'h4321, 1'b0, 1'b1, res, lat, bc, dn);
    n_tests++;
    if (res !== {16'h5556, 2'b00} || lat !== 5) begin
      n_fail++;
      $display("FAIL abort_recover: got %h lat %0d required %h lat 5", res, lat, {16'h5556, 2'b00});
    end
  endtask

  task automatic test_random();
    logic [17:0] res, exp;
    logic [15:0] aa, bb;
    logic        sb, c, dn;
    int          lat, bc, w;
    for (int k = 0; k < 3; k++) begin
      w = (k == 0) ? 1 : (k == 1) ? 4 : 16;
      for (int i = 0; i < 1000; i++) begin
        aa  = 16'($urandom);
        bb  = 16'($urandom);
        sb  = 1'($urandom_range(1));
        c   = 1'($urandom_range(1));
        run_op(w, aa, bb, sb, c, res, lat, bc, dn);
        exp = model(aa, bb, sb, c);
        n_tests++;
        if (res !== exp) begin
          n_fail++;
          $display("FAIL rand_c%0d_result: a=%h b=%h sub=%b ci=%b got %h required %h",
                   w, aa, bb, sb, c, res, exp);
        end
        n_tests++;
        if (lat !== 16 / w + 1) begin
          n_fail++;
          $display("FAIL rand_c%0d_latency: got %0d required %0d", w, lat, 16 / w + 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_add_edges();
    test_sub();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
